// File: rtl/ex_alu1_issue_buffer.sv
// Holding FIFO between scheduler1 and ALU1: the head op stays put while ALU1 is locked.
// Head outputs come from registered state only, so ALU1's lock can depend on the offered op.
module ex_alu1_issue_buffer #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_N   = 2,
  parameter int PAYLOAD_W = 99
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iFREE_EX,
  input  logic                 iSCHE_VALID,
  input  logic [PAYLOAD_W-1:0] iSCHE_DATA,
  output logic                 oSCHE_BUSY,
  output logic                 oALU1_VALID,
  output logic [PAYLOAD_W-1:0] oALU1_DATA,
  input  logic                 iALU1_LOCK,
  output logic [DEPTH_N:0]     oCOUNT,
  output logic                 oOVERFLOW,
  output logic [15:0]          oSTALL_CNT
);
  localparam logic [DEPTH_N:0] FULL    = (DEPTH_N+1)'(DEPTH);
  localparam logic [DEPTH_N:0] BUSY_TH = (DEPTH_N+1)'(DEPTH-1);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [DEPTH_N-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_N:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          stall_q, stall_d;
  logic                 rd, wr;

  assign oALU1_VALID = (count_q != '0);
  assign oALU1_DATA  = oALU1_VALID ? mem_q[rd_ptr_q] : '0;
  assign oSCHE_BUSY  = (count_q >= BUSY_TH);
  assign oCOUNT      = count_q;
  assign oOVERFLOW   = ovf_q;
  assign oSTALL_CNT  = stall_q;

  // A pop frees a slot in the same edge, so a full buffer still accepts a write then.
  assign rd = oALU1_VALID && !iALU1_LOCK;
  assign wr = iSCHE_VALID && ((count_q < FULL) || rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    stall_d  = stall_q;
    // Stall accounting survives a flush; it is a performance counter, not pipeline state.
    if (oALU1_VALID && iALU1_LOCK && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
    if (iFREE_EX) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr && !rd)      count_d = count_q + 1'b1;
      else if (rd && !wr) count_d = count_q - 1'b1;
      if (iSCHE_VALID && !wr) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      stall_q  <= stall_d;
    end
  end

  // Entry contents are only observed while count is nonzero, so they need no reset.
  always_ff @(posedge iCLOCK) begin
    if (wr && !iFREE_EX) mem_q[wr_ptr_q] <= iSCHE_DATA;
  end
endmodule

// File: tb/tb_ex_alu1_issue_buffer.sv
// Directed bench for ex_alu1_issue_buffer: a vector table plus hand sequences for
// refill, wrap-around, flush and asynchronous reset.
module tb_ex_alu1_issue_buffer;
  localparam int PW = 99;

  logic          iCLOCK = 1'b0, inRESET = 1'b0, iFREE_EX = 1'b0, iSCHE_VALID = 1'b0, iALU1_LOCK = 1'b0;
  logic [PW-1:0] iSCHE_DATA = '0;
  logic          oSCHE_BUSY, oALU1_VALID, oOVERFLOW;
  logic [PW-1:0] oALU1_DATA;
  logic [2:0]    oCOUNT;
  logic [15:0]   oSTALL_CNT;
  int n_cmp = 0, n_bad = 0;

  ex_alu1_issue_buffer #(.DEPTH(4), .DEPTH_N(2), .PAYLOAD_W(PW)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFREE_EX(iFREE_EX),
    .iSCHE_VALID(iSCHE_VALID), .iSCHE_DATA(iSCHE_DATA), .oSCHE_BUSY(oSCHE_BUSY),
    .oALU1_VALID(oALU1_VALID), .oALU1_DATA(oALU1_DATA), .iALU1_LOCK(iALU1_LOCK),
    .oCOUNT(oCOUNT), .oOVERFLOW(oOVERFLOW), .oSTALL_CNT(oSTALL_CNT));

  always #5 iCLOCK = ~iCLOCK;

  // Every field derived from the tag so any misplaced or corrupted bit shows up.
  function automatic logic [PW-1:0] mk(input logic [5:0] t);
    logic [31:0] s0;
    s0 = 32'hA5A5_0000 | {26'd0, t};
    return {t, t[4:0], t[3:0] ^ 4'hF, 7'b1010101, s0, ~s0, 1'b1, t + 6'd1, 1'b0, 1'b1, t[3:0]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic step(input logic v, input logic [5:0] t, input logic lk, input logic fl);
    iSCHE_VALID = v;
    iSCHE_DATA  = v ? mk(t) : '0;
    iALU1_LOCK  = lk;
    iFREE_EX    = fl;
    @(posedge iCLOCK);
    #1;
    iSCHE_VALID = 1'b0;
    iFREE_EX    = 1'b0;
  endtask

  typedef struct {
    logic v; logic [5:0] tag; logic lk;
    logic ev; logic [5:0] etag; int ecnt; logic ebusy; logic eovf; int estall;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mv(input logic v, input int tag, input logic lk, input logic ev,
                              input int etag, input int ecnt, input logic ebusy,
                              input logic eovf, input int estall);
    vec_t r;
    r.v = v; r.tag = 6'(tag); r.lk = lk; r.ev = ev; r.etag = 6'(etag);
    r.ecnt = ecnt; r.ebusy = ebusy; r.eovf = eovf; r.estall = estall;
    return r;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, 128'(oALU1_VALID), 128'd0);
    chk({nm, " data"},  128'(oALU1_DATA),  128'd0);
    chk({nm, " count"}, 128'(oCOUNT),      128'd0);
    chk({nm, " busy"},  128'(oSCHE_BUSY),  128'd0);
    chk({nm, " ovf"},   128'(oOVERFLOW),   128'd0);
    chk({nm, " stall"}, 128'(oSTALL_CNT),  128'd0);
  endtask

  initial begin
    int q[$];
    int nxt, got;
    logic lk, rd, wr;
    logic [5:0] t;

    // Back-to-back flow, lock hold with refill, then fill to overflow.
    tbl.push_back(mv(1, 1, 0,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mv(1, 2, 0,  1, 2, 1, 0, 0, 0));
    tbl.push_back(mv(1, 3, 0,  1, 3, 1, 0, 0, 0));
    tbl.push_back(mv(0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mv(1, 7, 0,  1, 7, 1, 0, 0, 0));
    tbl.push_back(mv(1, 8, 1,  1, 7, 2, 0, 0, 1));
    tbl.push_back(mv(1, 9, 1,  1, 7, 3, 1, 0, 2));
    tbl.push_back(mv(0, 0, 1,  1, 7, 3, 1, 0, 3));
    tbl.push_back(mv(0, 0, 1,  1, 7, 3, 1, 0, 4));
    tbl.push_back(mv(0, 0, 1,  1, 7, 3, 1, 0, 5));
    tbl.push_back(mv(0, 0, 0,  1, 8, 2, 0, 0, 5));
    tbl.push_back(mv(0, 0, 0,  1, 9, 1, 0, 0, 5));
    tbl.push_back(mv(0, 0, 0,  0, 0, 0, 0, 0, 5));
    tbl.push_back(mv(1, 10, 1, 1, 10, 1, 0, 0, 5));
    tbl.push_back(mv(1, 11, 1, 1, 10, 2, 0, 0, 6));
    tbl.push_back(mv(1, 12, 1, 1, 10, 3, 1, 0, 7));
    tbl.push_back(mv(1, 13, 1, 1, 10, 4, 1, 0, 8));
    tbl.push_back(mv(1, 14, 1, 1, 10, 4, 1, 1, 9));

    repeat (2) @(posedge iCLOCK);
    #1;
    chk_zero("reset");
    inRESET = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].tag, tbl[i].lk, 1'b0);
      chk($sformatf("vec%0d valid", i), 128'(oALU1_VALID), 128'(tbl[i].ev));
      chk($sformatf("vec%0d data", i),  128'(oALU1_DATA),  tbl[i].ev ? 128'(mk(tbl[i].etag)) : 128'd0);
      chk($sformatf("vec%0d count", i), 128'(oCOUNT),      128'(tbl[i].ecnt));
      chk($sformatf("vec%0d busy", i),  128'(oSCHE_BUSY),  128'(tbl[i].ebusy));
      chk($sformatf("vec%0d ovf", i),   128'(oOVERFLOW),   128'(tbl[i].eovf));
      chk($sformatf("vec%0d stall", i), 128'(oSTALL_CNT),  128'(tbl[i].estall));
    end

    // Fresh reset, then a write into a full buffer on a pop cycle must be accepted.
    inRESET = 1'b0;
    #1;
    chk_zero("rst2");
    @(negedge iCLOCK);
    inRESET = 1'b1;
    for (int k = 20; k < 24; k++) step(1'b1, 6'(k), 1'b1, 1'b0);
    chk("full count", 128'(oCOUNT), 128'd4);
    step(1'b1, 6'd24, 1'b0, 1'b0);
    chk("refill count", 128'(oCOUNT), 128'd4);
    chk("refill ovf",   128'(oOVERFLOW), 128'd0);
    for (int k = 21; k < 25; k++) begin
      chk($sformatf("refill head%0d", k), 128'(oALU1_DATA), 128'(mk(6'(k))));
      step(1'b0, 6'd0, 1'b0, 1'b0);
    end
    chk("refill empty", 128'(oCOUNT), 128'd0);

    // Wrap-around: ten ops against a lock that toggles every cycle, checked by a queue model.
    nxt = 0;
    got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      lk = c[0];
      rd = (q.size() != 0) && !lk;
      wr = (nxt < 10) && ((q.size() < 4) || rd);
      t  = 6'(nxt);
      if (rd) begin
        chk($sformatf("wrap head%0d", got), 128'(oALU1_DATA), 128'(mk(6'(q[0]))));
        void'(q.pop_front());
        got++;
      end
      if (wr) begin
        q.push_back(nxt);
        nxt++;
      end
      step(wr, t, lk, 1'b0);
      chk($sformatf("wrap count c%0d", c), 128'(oCOUNT), 128'(q.size()));
    end
    chk("wrap delivered", 128'(got), 128'd10);
    chk("wrap ovf", 128'(oOVERFLOW), 128'd0);

    // Flush with three queued ops and a simultaneous write.
    for (int k = 30; k < 33; k++) step(1'b1, 6'(k), 1'b1, 1'b0);
    chk("preflush count", 128'(oCOUNT), 128'd3);
    step(1'b1, 6'd33, 1'b0, 1'b1);
    chk("flush count", 128'(oCOUNT),      128'd0);
    chk("flush valid", 128'(oALU1_VALID), 128'd0);
    chk("flush data",  128'(oALU1_DATA),  128'd0);
    chk("flush ovf",   128'(oOVERFLOW),   128'd0);
    step(1'b0, 6'd0, 1'b0, 1'b0);
    chk("postflush count", 128'(oCOUNT), 128'd0);

    // Asynchronous reset between clock edges with two ops queued.
    step(1'b1, 6'd40, 1'b1, 1'b0);
    step(1'b1, 6'd41, 1'b1, 1'b0);
    chk("prerst count", 128'(oCOUNT), 128'd2);
    #2 inRESET = 1'b0;
    #1;
    chk_zero("async rst");
    @(negedge iCLOCK);
    inRESET = 1'b1;
    iALU1_LOCK = 1'b0;
    step(1'b0, 6'd0, 1'b0, 1'b0);
    chk("after rst count", 128'(oCOUNT), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
